// File: rtl/uart_rx_frame.sv
// UART receiver with parametrised data width, parity and framing-error reporting.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around mid-bit.
module uart_rx_frame #(
  parameter int CLK_DIV   = 5208,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0
) (
  input  logic                 sclk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] po_data,
  output logic                 po_flag,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 rx_busy
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] TOPB = BW'(DATA_BITS - 1);
  localparam bit PAR_EN  = (PARITY == 1) || (PARITY == 2);
  localparam bit PAR_ODD = (PARITY == 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PAR, STOP
  } state_t;

  state_t               state;
  logic                 rx_m, rx_s, rx_s_d;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bidx;
  logic [DATA_BITS-1:0] sr;
  logic                 perr_q;
  logic                 tick;
  logic                 bit_v;
  logic                 exp_par;
  logic                 start_det;

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      rx_m   <= 1'b1;
      rx_s   <= 1'b1;
      rx_s_d <= 1'b1;
    end else begin
      rx_m   <= rx;
      rx_s   <= rx_m;
      rx_s_d <= rx_s;
    end
  end

  assign start_det = !rx_s && rx_s_d;

`ifdef UART_RX_MAJORITY_EN
  localparam logic [CW-1:0] HM1 = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] HP1 = CW'(CLK_DIV / 2 + 1);
  logic [1:0] mv;

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      mv <= 2'b11;
    end else begin
      if (cnt == HM1) mv[0] <= rx_s;
      if (cnt == HALF) mv[1] <= rx_s;
    end
  end

  // Third vote is the live sample, so the decision lands one cycle late
  assign tick  = (cnt == HP1);
  assign bit_v = (mv[0] & mv[1]) | (mv[0] & rx_s) | (mv[1] & rx_s);
`else
  assign tick  = (cnt == HALF);
  assign bit_v = rx_s;
`endif

  assign exp_par = PAR_ODD ? ~^sr : ^sr;

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bidx       <= '0;
      sr         <= '0;
      perr_q     <= 1'b0;
      po_data    <= '0;
      po_flag    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      rx_busy    <= 1'b0;
    end else begin
      po_flag    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      if (state != IDLE)
        cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      unique case (state)
        IDLE: begin
          if (start_det) begin
            state   <= START;
            cnt     <= '0;
            rx_busy <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            if (bit_v) begin
              state   <= IDLE;
              cnt     <= '0;
              rx_busy <= 1'b0;
            end else begin
              state  <= DATA;
              bidx   <= '0;
              perr_q <= 1'b0;
            end
          end
        end
        DATA: begin
          if (tick) begin
            sr   <= {bit_v, sr[DATA_BITS-1:1]};
            bidx <= bidx + 1'b1;
            if (bidx == TOPB)
              state <= PAR_EN ? PAR : STOP;
          end
        end
        PAR: begin
          if (tick) begin
            perr_q <= bit_v ^ exp_par;
            state  <= STOP;
          end
        end
        STOP: begin
          if (tick) begin
            po_data <= sr;
            state   <= IDLE;
            cnt     <= '0;
            rx_busy <= 1'b0;
            // A low stop bit makes the word untrustworthy; parity is moot
            if (bit_v) begin
              po_flag    <= 1'b1;
              parity_err <= perr_q;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame: four instances covering 8N1,
// 7E1, 5O1 and 9O1 frames, with framing, break, glitch and reset cases.
module tb_uart_rx_frame;

`ifdef UART_RX_MAJORITY_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif
  localparam int CD = 16;

  typedef struct {
    logic       flag;
    logic       perr;
    logic       ferr;
    logic [8:0] data;
    int         cyc;
  } exp_t;

  logic sclk = 1'b0;
  logic rst  = 1'b1;
  logic rx_v [4];
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  logic [7:0] d0;
  logic [6:0] d1;
  logic [4:0] d2;
  logic [8:0] d3;
  logic       fl [4];
  logic       pe [4];
  logic       fe [4];
  logic       bz [4];

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  exp_t q3[$];

  always #5 sclk = ~sclk;
  always @(posedge sclk) cyc = cyc + 1;

  uart_rx_frame #(.CLK_DIV(CD), .DATA_BITS(8), .PARITY(0)) u0 (
    .sclk(sclk), .rst(rst), .rx(rx_v[0]), .po_data(d0),
    .po_flag(fl[0]), .parity_err(pe[0]), .frame_err(fe[0]),
    .rx_busy(bz[0]));
  uart_rx_frame #(.CLK_DIV(CD), .DATA_BITS(7), .PARITY(2)) u1 (
    .sclk(sclk), .rst(rst), .rx(rx_v[1]), .po_data(d1),
    .po_flag(fl[1]), .parity_err(pe[1]), .frame_err(fe[1]),
    .rx_busy(bz[1]));
  uart_rx_frame #(.CLK_DIV(CD), .DATA_BITS(5), .PARITY(1)) u2 (
    .sclk(sclk), .rst(rst), .rx(rx_v[2]), .po_data(d2),
    .po_flag(fl[2]), .parity_err(pe[2]), .frame_err(fe[2]),
    .rx_busy(bz[2]));
  uart_rx_frame #(.CLK_DIV(CD), .DATA_BITS(9), .PARITY(1)) u3 (
    .sclk(sclk), .rst(rst), .rx(rx_v[3]), .po_data(d3),
    .po_flag(fl[3]), .parity_err(pe[3]), .frame_err(fe[3]),
    .rx_busy(bz[3]));

  function automatic logic [8:0] dat_of(input int d);
    case (d)
      0: return {1'b0, d0};
      1: return {2'b0, d1};
      2: return {4'b0, d2};
      default: return d3;
    endcase
  endfunction

  function automatic int qsize(input int d);
    case (d)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  function automatic exp_t qhead(input int d);
    case (d)
      0: return q0[0];
      1: return q1[0];
      2: return q2[0];
      default: return q3[0];
    endcase
  endfunction

  function automatic exp_t qpop(input int d);
    case (d)
      0: return q0.pop_front();
      1: return q1.pop_front();
      2: return q2.pop_front();
      default: return q3.pop_front();
    endcase
  endfunction

  task automatic qpush(input int d, input exp_t e);
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      2: q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endtask

  task automatic chk(input string nm, input int d,
                     input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s dut%0d got=%0h want=%0h cyc=%0d",
               nm, d, got, want, cyc);
    end
  endtask

  task automatic mon(input int d);
    exp_t e;
    if (fl[d] || pe[d] || fe[d]) begin
      if (qsize(d) == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe dut%0d flag=%b perr=%b ferr=%b want none cyc=%0d",
                 d, fl[d], pe[d], fe[d], cyc);
      end else begin
        e = qpop(d);
        chk("strobe_cycle", d, cyc, e.cyc);
        chk("po_flag", d, 32'(fl[d]), 32'(e.flag));
        chk("parity_err", d, 32'(pe[d]), 32'(e.perr));
        chk("frame_err", d, 32'(fe[d]), 32'(e.ferr));
        chk("busy_at_strobe", d, 32'(bz[d]), 0);
        if (e.flag)
          chk("po_data", d, 32'(dat_of(d)), 32'(e.data));
      end
    end else if (qsize(d) != 0 && cyc > qhead(d).cyc) begin
      e = qpop(d);
      checks++;
      errors++;
      $display("FAIL missed_strobe dut%0d got none want strobe at cyc=%0d",
               d, e.cyc);
    end
  endtask

  always @(negedge sclk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) mon(i);
    end
  end

  task automatic bitx(input int d, input logic b);
    rx_v[d] = b;
    repeat (CD) @(posedge sclk);
    #1;
  endtask

  task automatic send(input int d, input int nb, input logic [8:0] data,
                      input int pen, input logic pbit, input logic stopb,
                      input logic eperr);
    exp_t e;
    e.flag = stopb;
    e.ferr = !stopb;
    e.perr = stopb & eperr;
    e.data = data;
    e.cyc  = cyc + 12 + (nb + pen + 1) * CD + LAT;
    qpush(d, e);
    bitx(d, 1'b0);
    chk("busy_in_frame", d, 32'(bz[d]), 1);
    for (int i = 0; i < nb; i++) bitx(d, data[i]);
    if (pen != 0) bitx(d, pbit);
    bitx(d, stopb);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge sclk);
    #1;
  endtask

  task automatic chk_zero(input string nm, input int d);
    chk(nm, d, {27'b0, fl[d], pe[d], fe[d], bz[d], dat_of(d) != 0}, 0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) rx_v[i] = 1'b1;
    idle(3);
    for (int i = 0; i < 4; i++) chk_zero("reset_outputs", i);
    rst = 1'b0;
    idle(4);

    // 8N1 back-to-back
    send(0, 8, 9'h0A5, 0, 1'b0, 1'b1, 1'b0);
    send(0, 8, 9'h03C, 0, 1'b0, 1'b1, 1'b0);
    idle(2 * CD);

    // 7E1: correct parity 0, then wrong parity 1
    send(1, 7, 9'h041, 1, 1'b0, 1'b1, 1'b0);
    send(1, 7, 9'h041, 1, 1'b1, 1'b1, 1'b1);
    idle(2 * CD);

    // stop bit low, then break for 40 bit times
    send(0, 8, 9'h055, 0, 1'b0, 1'b0, 1'b0);
    idle(40 * CD);
    rx_v[0] = 1'b1;
    idle(2 * CD);
    send(0, 8, 9'h012, 0, 1'b0, 1'b1, 1'b0);
    idle(2 * CD);

    // short low glitch rejected in START
    rx_v[0] = 1'b0;
    idle(3);
    rx_v[0] = 1'b1;
    idle(3 * CD);
    chk("glitch_idle", 0, 32'(bz[0]), 0);

    // reset during data bit 4 of 0x81
    bitx(0, 1'b0);
    bitx(0, 1'b1);
    bitx(0, 1'b0);
    bitx(0, 1'b0);
    bitx(0, 1'b0);
    rx_v[0] = 1'b0;
    idle(8);
    rst = 1'b1;
    rx_v[0] = 1'b1;
    #1;
    chk_zero("reset_midframe", 0);
    idle(4);
    chk_zero("reset_hold", 0);
    rst = 1'b0;
    idle(3 * CD);
    send(0, 8, 9'h07E, 0, 1'b0, 1'b1, 1'b0);
    idle(2 * CD);

    // width extremes, odd parity
    send(2, 5, 9'h015, 1, 1'b0, 1'b1, 1'b0);
    send(2, 5, 9'h015, 1, 1'b1, 1'b1, 1'b1);
    send(3, 9, 9'h1A3, 1, 1'b0, 1'b1, 1'b0);
    idle(2 * CD);

`ifdef UART_RX_MAJORITY_EN
    fork
      send(0, 8, 9'h0FF, 0, 1'b0, 1'b1, 1'b0);
      begin
        idle(56);
        rx_v[0] = 1'b0;
        idle(1);
        rx_v[0] = 1'b1;
      end
    join
    idle(2 * CD);
`endif

    idle(3 * CD);
    for (int i = 0; i < 4; i++) chk("queue_drained", i, qsize(i), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
